// File: rtl/serial_byte_loader_pkg.sv
// Shared constants for serial_byte_loader: default word width, hold-stage
// state encoding and the bit-counter width helper.
package serial_byte_loader_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Hold stage: EMPTY means no word waiting, FULL means DOUT carries a word.
  localparam logic [0:0] HOLD_EMPTY = 1'b0;
  localparam logic [0:0] HOLD_FULL  = 1'b1;

  // Bits needed to count 0..w (covers the extra parity slot as well).
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_byte_loader_bit_counter.sv
// Wrap-around counter 0..LAST with enable, synchronous active-high clear
// and a terminal-count flag that is high while the count equals LAST.
module bit_counter #(
  parameter int unsigned W    = 4,
  parameter int unsigned LAST = 7
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] LASTV = W'(LAST);

  logic [W-1:0] cnt;

  assign tc = (cnt == LASTV);

  // Count enabled events, wrapping to zero after LAST.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/serial_byte_loader.sv
// Serial-to-parallel loader: shifts accepted SIN bits into WIDTH-bit words
// and presents them on DOUT through a one-word holding stage with a
// valid/ready handshake on both sides.
// Optional build macro PARITY_SEL_EN: each word is followed by an even-parity
// bit and the PERR port reports the check result alongside the word.
module serial_byte_loader
  import serial_byte_loader_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SIN,
  input  logic             SVALID,
  output logic             SREADY,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID,
  input  logic             DREADY
`ifdef PARITY_SEL_EN
  ,
  output logic             PERR
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH);
`ifdef PARITY_SEL_EN
  localparam int unsigned LAST = WIDTH;
`else
  localparam int unsigned LAST = WIDTH - 1;
`endif

  logic             accept;
  logic             tc;
  logic             complete;
  logic             shift_en;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic [0:0]       state;

  assign accept   = SVALID && SREADY && !RST;
  assign complete = accept && tc;

  // Never accept the bit that would complete a word while the hold stage is
  // still occupied; depends on registered state only.
  assign SREADY = !((state == HOLD_FULL) && tc);
  assign DVALID = (state == HOLD_FULL);

  bit_counter #(
    .W    (CW),
    .LAST (LAST)
  ) u_cnt (
    .CLK (CLK),
    .RST (RST),
    .en  (accept),
    .tc  (tc)
  );

  // Next shift-register value with SIN inserted at the configured end.
  always_comb begin
    shifted = sreg;
    if (MSB_FIRST) begin
      shifted = {sreg[WIDTH-2:0], SIN};
    end else begin
      shifted = {SIN, sreg[WIDTH-1:1]};
    end
  end

`ifdef PARITY_SEL_EN
  // Parity slot: the data is already fully shifted in when the parity bit
  // arrives, so the stored word is sreg itself and SIN is excluded from it.
  assign shift_en = accept && !tc;
  assign word     = sreg;
`else
  // The completing bit is part of the word, so store the shifted value.
  assign shift_en = accept;
  assign word     = shifted;
`endif

  // Shift register for the word being assembled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sreg <= '0;
    end else if (shift_en) begin
      sreg <= shifted;
    end
  end

  // Hold stage: refill on completion takes priority over drain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= HOLD_EMPTY;
      DOUT  <= '0;
    end else if (complete) begin
      state <= HOLD_FULL;
      DOUT  <= word;
    end else if ((state == HOLD_FULL) && DREADY) begin
      state <= HOLD_EMPTY;
    end
  end

`ifdef PARITY_SEL_EN
  // Parity result registered together with the hold write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PERR <= 1'b0;
    end else if (complete) begin
      PERR <= (^sreg) ^ SIN;
    end
  end
`endif

endmodule

// File: tb/tb_serial_byte_loader.sv
// Self-checking bench for serial_byte_loader: directed scenarios with literal
// expectations followed by randomized traffic against a queue-based model.
module tb_serial_byte_loader;

  localparam int WIDTH     = 8;
  localparam bit MSB_FIRST = 1'b1;
`ifdef PARITY_SEL_EN
  localparam int WLEN = WIDTH + 1;
`else
  localparam int WLEN = WIDTH;
`endif

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             SIN = 1'b0;
  logic             SVALID = 1'b0;
  logic             DREADY = 1'b0;
  logic             SREADY;
  logic             DVALID;
  logic [WIDTH-1:0] DOUT;
`ifdef PARITY_SEL_EN
  logic             PERR;
`endif

  serial_byte_loader #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .SIN    (SIN),
    .SVALID (SVALID),
    .SREADY (SREADY),
    .DOUT   (DOUT),
    .DVALID (DVALID),
    .DREADY (DREADY)
`ifdef PARITY_SEL_EN
    ,
    .PERR   (PERR)
`endif
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;

  // Behavioural model: accepted bits of the word in progress, plus the word
  // waiting downstream.
  bit               q[$];
  bit               m_full = 1'b0;
  logic [WIDTH-1:0] m_dout = '0;
  bit               m_perr = 1'b0;
  bit               m_known = 1'b0;

  function automatic bit m_sready();
    return !(m_full && (q.size() == WLEN - 1));
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit acc;
    bit take;
    bit p;
    if (RST) begin
      q.delete();
      m_full  = 1'b0;
      m_dout  = '0;
      m_perr  = 1'b0;
      m_known = 1'b1;
    end else if (m_known) begin
      acc  = SVALID && m_sready();
      take = m_full && DREADY;
      if (acc) q.push_back(SIN);
      if (q.size() == WLEN) begin
        p = 1'b0;
        for (int i = 0; i < WLEN; i++) p ^= q[i];
        for (int i = 0; i < WIDTH; i++) begin
          if (MSB_FIRST) m_dout[WIDTH-1-i] = q[i];
          else           m_dout[i] = q[i];
        end
        m_perr = p;
        m_full = 1'b1;
        q.delete();
      end else if (take) begin
        m_full = 1'b0;
      end
    end
  endtask

  task automatic compare();
    if (m_known) begin
      check("sready", {31'd0, SREADY}, {31'd0, m_sready()});
      check("dvalid", {31'd0, DVALID}, {31'd0, m_full});
      check("dout", 32'(DOUT), 32'(m_dout));
`ifdef PARITY_SEL_EN
      check("perr", {31'd0, PERR}, {31'd0, m_perr});
`endif
    end
  endtask

  // One clock: drive inputs, update model at the edge, compare mid-cycle.
  task automatic step(input logic r, input logic sv, input logic s, input logic dr);
    RST = r; SVALID = sv; SIN = s; DREADY = dr;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare();
  endtask

  // Bit k of the serial sequence for word w, MSB sent first; the trailing
  // slot (parity builds only) is even parity, inverted when flip is set.
  function automatic logic seq_bit(input logic [WIDTH-1:0] w, input int k, input bit flip);
    if (k < WIDTH) return w[WIDTH-1-k];
    return (^w) ^ flip;
  endfunction

  task automatic send(input logic [WIDTH-1:0] w, input bit flip, input logic dr, input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, seq_bit(w, k, flip), dr);
  endtask

  logic [WIDTH-1:0] pair [2];

  initial begin
    // Reset
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_dvalid", {31'd0, DVALID}, 32'd0);
    check("rst_sready", {31'd0, SREADY}, 32'd1);
    check("rst_dout", 32'(DOUT), 32'd0);

    // Single word
    send(8'hAA, 1'b0, 1'b1, WLEN);
    check("t1_dvalid", {31'd0, DVALID}, 32'd1);
    check("t1_dout", 32'(DOUT), 32'hAA);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_drop", {31'd0, DVALID}, 32'd0);

    // Back-to-back words
    pair[0] = 8'hAA;
    pair[1] = 8'h55;
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < WLEN; k++) begin
        check("t2_sready", {31'd0, SREADY}, 32'd1);
        step(1'b0, 1'b1, seq_bit(pair[w], k, 1'b0), 1'b1);
        if (w == 1 && k == WLEN - 2) check("t2_dout_hold", 32'(DOUT), 32'hAA);
      end
      check("t2_dout", 32'(DOUT), 32'(pair[w]));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure
    send(8'hAA, 1'b0, 1'b0, WLEN);
    check("t3_dout_a", 32'(DOUT), 32'hAA);
    send(8'h55, 1'b0, 1'b0, WLEN - 1);
    check("t3_stall", {31'd0, SREADY}, 32'd0);
    check("t3_held", 32'(DOUT), 32'hAA);
    step(1'b0, 1'b1, seq_bit(8'h55, WLEN - 1, 1'b0), 1'b1);
    check("t3_drain", {31'd0, DVALID}, 32'd0);
    check("t3_ready", {31'd0, SREADY}, 32'd1);
    step(1'b0, 1'b1, seq_bit(8'h55, WLEN - 1, 1'b0), 1'b0);
    check("t3_dout_b", 32'(DOUT), 32'h55);
    check("t3_dvalid_b", {31'd0, DVALID}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word
    send(8'hFF, 1'b0, 1'b1, 4);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("t4_rst_dvalid", {31'd0, DVALID}, 32'd0);
    send(8'h55, 1'b0, 1'b1, WLEN);
    check("t4_dout", 32'(DOUT), 32'h55);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Gapped input
    for (int k = 0; k < WLEN; k++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      check("t5_early", {31'd0, DVALID}, 32'd0);
      step(1'b0, 1'b1, seq_bit(8'hC3, k, 1'b0), 1'b1);
      if (k < WLEN - 1) check("t5_early", {31'd0, DVALID}, 32'd0);
    end
    check("t5_dout", 32'(DOUT), 32'hC3);
    check("t5_dvalid", {31'd0, DVALID}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef PARITY_SEL_EN
    // Parity
    send(8'hAA, 1'b0, 1'b1, WLEN);
    check("t6_perr0", {31'd0, PERR}, 32'd0);
    send(8'hAA, 1'b1, 1'b1, WLEN);
    check("t6_perr1", {31'd0, PERR}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step(1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
